// File: rtl/pulse_latch_bank_pkg.sv
// pulse_latch_bank_pkg
// Shared definitions for the pulse latch bank.
//   ev_state_e          : event-port FSM state encoding (IDLE, PRESENT)
//   channel_index_width : width of a channel index, clog2 with a floor of 1
//   sat_max             : all-ones saturation value for a counter of given width
package pulse_latch_bank_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } ev_state_e;

  function automatic int channel_index_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_latch_counter.sv
// pulse_latch_counter
// One channel of the bank: pending level, saturating pulse counter and sticky
// overflow, with the clear-versus-pulse priority rule.
// Ports:
//   clock, reset  : clock and asynchronous active-high reset
//   clr_i         : combined clear for this channel (external clear or accept)
//   pulse_i       : event pulse, sampled every edge
//   level_o       : pending level
//   count_o       : saturating pulse count
//   overflow_o    : sticky overflow, set by a pulse arriving at saturation
module pulse_latch_counter
  import pulse_latch_bank_pkg::*;
#(
  parameter int   COUNT_WIDTH    = 4,
  parameter logic RESET_LEVEL    = 1'b0,
  parameter int   CLEAR_PRIORITY = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clr_i,
  input  logic                   pulse_i,
  output logic                   level_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   overflow_o
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(sat_max(COUNT_WIDTH));
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = COUNT_WIDTH'(0);
  // A channel that resets pending is treated as having seen one event.
  localparam logic [COUNT_WIDTH-1:0] CNT_RST = COUNT_WIDTH'(RESET_LEVEL);

  logic                   level_q, level_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;

  // Next-state: clear/pulse priority, then saturating count.
  always_comb begin
    level_d = level_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i && pulse_i) begin
      // Coincident clear and pulse: either a fresh event or a full drop.
      if (CLEAR_PRIORITY == 0) begin
        level_d = 1'b1;
        count_d = CNT_ONE;
        ovf_d   = 1'b0;
      end else begin
        level_d = 1'b0;
        count_d = CNT_ZERO;
        ovf_d   = 1'b0;
      end
    end else if (clr_i) begin
      level_d = 1'b0;
      count_d = CNT_ZERO;
      ovf_d   = 1'b0;
    end else if (pulse_i) begin
      level_d = 1'b1;
      if (count_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else begin
      level_d = level_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= RESET_LEVEL;
      count_q <= CNT_RST;
      ovf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign level_o    = level_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/pulse_latch_bank.sv
// pulse_latch_bank
// Bank of pulse latches with saturating counters, plus a valid/ready event
// port that presents the lowest-index pending channel. Accepting an event
// clears its channel.
// Ports:
//   clock, reset    : clock and asynchronous active-high reset
//   clear           : per-channel synchronous clear
//   pulse_in        : per-channel event pulse
//   level_out       : per-channel pending level
//   count_out       : per-channel counts, channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   overflow_out    : per-channel sticky overflow
//   event_valid     : registered event valid
//   event_ready     : consumer ready
//   event_channel   : registered index of the presented channel
//   event_count     : live count of the presented channel
//   event_overflow  : live overflow of the presented channel
module pulse_latch_bank
  import pulse_latch_bank_pkg::*;
#(
  parameter int                      CHANNEL_COUNT  = 8,
  parameter int                      COUNT_WIDTH    = 4,
  parameter logic [CHANNEL_COUNT-1:0] RESET_VALUE   = {CHANNEL_COUNT{1'b0}},
  parameter int                      CLEAR_PRIORITY = 0,
  localparam int                     CHANNEL_INDEX_WIDTH = channel_index_width(CHANNEL_COUNT)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [CHANNEL_COUNT-1:0]             clear,
  input  logic [CHANNEL_COUNT-1:0]             pulse_in,
  output logic [CHANNEL_COUNT-1:0]             level_out,
  output logic [CHANNEL_COUNT*COUNT_WIDTH-1:0] count_out,
  output logic [CHANNEL_COUNT-1:0]             overflow_out,
  output logic                                 event_valid,
  input  logic                                 event_ready,
  output logic [CHANNEL_INDEX_WIDTH-1:0]       event_channel,
  output logic [COUNT_WIDTH-1:0]               event_count,
  output logic                                 event_overflow
);

  ev_state_e                      state_q;
  logic                           event_valid_q;
  logic [CHANNEL_INDEX_WIDTH-1:0] event_channel_q;

  logic                           accept_s;
  logic [CHANNEL_COUNT-1:0]       clr_s;
  logic [CHANNEL_COUNT-1:0]       level_s;
  logic [CHANNEL_COUNT-1:0]       ovf_s;
  logic [COUNT_WIDTH-1:0]         cnt_arr_s [CHANNEL_COUNT];
  logic [CHANNEL_INDEX_WIDTH-1:0] sel_idx_s;
  logic                           any_pending_s;

  assign accept_s = event_valid_q & event_ready;

  for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_ch
    localparam logic [CHANNEL_INDEX_WIDTH-1:0] IDX = CHANNEL_INDEX_WIDTH'(gi);

    // Accepting the presented event clears exactly that channel.
    assign clr_s[gi] = clear[gi] | (accept_s & (event_channel_q == IDX));

    pulse_latch_counter #(
      .COUNT_WIDTH    (COUNT_WIDTH),
      .RESET_LEVEL    (RESET_VALUE[gi]),
      .CLEAR_PRIORITY (CLEAR_PRIORITY)
    ) u_counter (
      .clock      (clock),
      .reset      (reset),
      .clr_i      (clr_s[gi]),
      .pulse_i    (pulse_in[gi]),
      .level_o    (level_s[gi]),
      .count_o    (cnt_arr_s[gi]),
      .overflow_o (ovf_s[gi])
    );

    assign count_out[gi*COUNT_WIDTH +: COUNT_WIDTH] = cnt_arr_s[gi];
  end

  // Lowest-index pending channel: scan downwards so the lowest hit wins.
  always_comb begin
    sel_idx_s = {CHANNEL_INDEX_WIDTH{1'b0}};
    for (int i = CHANNEL_COUNT - 1; i >= 0; i--) begin
      sel_idx_s = level_s[i] ? CHANNEL_INDEX_WIDTH'(i) : sel_idx_s;
    end
    any_pending_s = |level_s;
  end

  // Event-port FSM with registered valid and channel index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      event_valid_q   <= 1'b0;
      event_channel_q <= {CHANNEL_INDEX_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_pending_s) begin
            state_q         <= ST_PRESENT;
            event_valid_q   <= 1'b1;
            event_channel_q <= sel_idx_s;
          end else begin
            state_q       <= ST_IDLE;
            event_valid_q <= 1'b0;
          end
        end
        ST_PRESENT: begin
          // Leave on accept, or abort if the locked channel is cleared externally.
          if (accept_s || clear[event_channel_q]) begin
            state_q       <= ST_IDLE;
            event_valid_q <= 1'b0;
          end else begin
            state_q       <= ST_PRESENT;
            event_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          event_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_out      = level_s;
  assign overflow_out   = ovf_s;
  assign event_valid    = event_valid_q;
  assign event_channel  = event_channel_q;
  // Live view of the locked channel; may advance while waiting for ready.
  assign event_count    = cnt_arr_s[event_channel_q];
  assign event_overflow = ovf_s[event_channel_q];

endmodule

// File: doc/pulse_latch_bank.md
Name: pulse_latch_bank

Overview:
Multi-channel successor to the single-bit pulse latch. Each channel captures transient pulses into a steady pending level and counts repeat pulses with saturation and an overflow flag. Channels clear individually. A registered event port presents the lowest-index pending channel over a valid/ready handshake; acceptance clears that channel. It sits between interrupt/event sources and a control FSM or CSR block that services events at its own pace.

Parameters:
CHANNEL_COUNT, 8, number of independent channels (>=2)
COUNT_WIDTH, 4, per-channel saturating pulse counter width (>=1)
RESET_VALUE, {CHANNEL_COUNT{1'b0}}, per-channel pending state after reset
CLEAR_PRIORITY, 0, 0 = coincident pulse survives a clear/accept; 1 = clear/accept wins and the pulse is dropped

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear  in  CHANNEL_COUNT  per-channel synchronous clear
pulse_in  in  CHANNEL_COUNT  per-channel event pulse, sampled every edge
level_out  out  CHANNEL_COUNT  per-channel pending level
count_out  out  CHANNEL_COUNT*COUNT_WIDTH  per-channel pulse count, channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
overflow_out  out  CHANNEL_COUNT  per-channel sticky overflow
event_valid  out  1  event port valid
event_ready  in  1  event port ready
event_channel  out  CHANNEL_INDEX_WIDTH  index of presented channel, clog2(CHANNEL_COUNT)
event_count  out  COUNT_WIDTH  live count of presented channel
event_overflow  out  1  live overflow of presented channel

Behaviour:
- Reset (async assert, sync release in the surrounding system): level_out=RESET_VALUE; count[i]=RESET_VALUE[i] (0 or 1); overflow_out=0; FSM=IDLE; event_valid=0; event_channel=0.
- Per channel, per edge: clr_i = clear[i] | (accept & event_channel==i), where accept = event_valid & event_ready.
- Pulse only: pending<=1; count<=count+1, saturating at 2^COUNT_WIDTH-1; if count already saturated, overflow<=1 and count is held.
- clr_i only: pending, count and overflow <=0.
- clr_i and pulse, CLEAR_PRIORITY=0: pending=1, count=1, overflow=0 (a fresh event). CLEAR_PRIORITY=1: all three =0.
- Neither: hold.
- Latency: pulse sampled at edge N -> level_out and count visible after edge N.
- FSM IDLE: if any pending, lock event_channel to the lowest pending index and go to PRESENT. event_valid is registered and rises one cycle after level_out.
- FSM PRESENT: event_valid=1. event_channel stays frozen while PRESENT.
  - event_count and event_overflow are muxed live from the locked channel, so they may increment while waiting; the consumer samples them at the handshake.
  - accept -> IDLE; the channel clears per the rules above.
  - external clear of the locked channel without accept -> IDLE. This is an abort: event_valid drops the following cycle.
- event_valid never depends combinationally on event_ready.
- Throughput: at most one event per 2 cycles.
- Starvation: higher-index channels wait behind lower ones. This is intended.
- With event_ready tied low, the block degenerates to a latch bank plus counters.

Decomposition:
- Package pulse_latch_bank_pkg:
  - FSM state encoding (IDLE, PRESENT).
  - CHANNEL_INDEX_WIDTH function, clog2 with a minimum of 1.
  - Saturation-max constant function of COUNT_WIDTH.
- Sub-module pulse_latch_counter: one channel's pending, count and overflow registers with the clear/pulse priority rule. Instantiated CHANNEL_COUNT times via generate.
- Top level holds the lowest-index priority select, the FSM and the event muxes.

Test Plan:
- Reset, then pulse_in=8'h04 for 1 cycle -> level_out=8'h04 next cycle, count[2]=1, event_valid=1 one cycle later with event_channel=2, event_count=1.
- Channel 5 pulsed 17 times with COUNT_WIDTH=4 and no accept -> count[5]=15, overflow_out[5]=1 from the 16th pulse onward.
- Pulse channels 6 then 1 while event_ready=0 and channel 6 already presented -> event_channel stays 6. Accept -> channel 6 clears, then channel 1 is presented 2 cycles later.
- clear[3] and pulse_in[3] in the same cycle with count[3]=7 -> CLEAR_PRIORITY=0: level=1, count=1. CLEAR_PRIORITY=1: level=0, count=0.
- Accept channel 0 while pulse_in[0]=1, CLEAR_PRIORITY=0 -> channel 0 re-pending with count=1 and re-presented after IDLE.
- Assert reset while PRESENT with several channels pending -> all outputs return immediately to reset values, including RESET_VALUE=8'h81 giving level_out=8'h81, count=1 on channels 0 and 7.
